// File: rtl/spin_speed_ramp_if.sv
// Handshake bundle between the wash-mode/button logic and the spin-speed ramp controller.
// The master side drives mode/buttons/run; the slave side returns the selection and ramp status.
interface spin_speed_ramp_if #(
  parameter int MODE_W  = 3,
  parameter int SPEED_W = 11
);
  logic [MODE_W-1:0]  wash_mode;
  logic               load;
  logic               increment;
  logic               decrement;
  logic               run;
  logic [SPEED_W-1:0] selected_spin_speed;
  logic [SPEED_W-1:0] motor_speed;
  logic               at_speed;
  logic               ramping;

  modport master (
    output wash_mode, load, increment, decrement, run,
    input  selected_spin_speed, motor_speed, at_speed, ramping
  );

  modport slave (
    input  wash_mode, load, increment, decrement, run,
    output selected_spin_speed, motor_speed, at_speed, ramping
  );
endinterface

// File: rtl/spin_speed_ramp_ctrl.sv
// Spin-speed selector with per-mode defaults/ceilings and wrap-around stepping,
// plus a rate-limited slew of the commanded motor speed toward the selection.
module spin_speed_ramp_ctrl #(
  parameter int MODE_W    = 3,
  parameter int SPEED_W   = 11,
  parameter int IDX_W     = 3,
  parameter int NUM_STEPS = 6,
  parameter logic [NUM_STEPS*SPEED_W-1:0] SPEED_TABLE =
    {11'd1400, 11'd1200, 11'd1000, 11'd800, 11'd400, 11'd0},
  parameter logic [(2**MODE_W)*IDX_W-1:0] DEFAULT_IDX =
    {3'd5, 3'd3, 3'd0, 3'd2, 3'd4, 3'd1, 3'd5, 3'd3},
  parameter logic [(2**MODE_W)*IDX_W-1:0] MAX_IDX =
    {3'd5, 3'd4, 3'd0, 3'd3, 3'd5, 3'd2, 3'd5, 3'd5},
  parameter int RAMP_DIV  = 4,
  parameter int RAMP_STEP = 200
) (
  input  logic              clk,
  input  logic              reset,
  spin_speed_ramp_if.slave  bus
);

  localparam int NUM_MODES = 2**MODE_W;
  localparam int TAB_SIZE  = 2**IDX_W;
  localparam int CNT_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [IDX_W-1:0]   dflt_tab [NUM_MODES];
  logic [IDX_W-1:0]   max_tab  [NUM_MODES];
  logic [SPEED_W-1:0] spd_tab  [TAB_SIZE];

  logic [IDX_W-1:0]   idx;
  logic               inc_q, dec_q;
  logic [CNT_W-1:0]   div_cnt;
  logic [SPEED_W-1:0] motor_speed;
  logic [SPEED_W-1:0] sel_speed;
  logic [SPEED_W-1:0] goal;
  logic               inc_p, dec_p, tick;

  // Unpack the parameter vectors so lookups are plain array reads; unused index slots read 0.
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode_tab
    assign dflt_tab[m] = DEFAULT_IDX[m*IDX_W +: IDX_W];
    assign max_tab[m]  = MAX_IDX[m*IDX_W +: IDX_W];
  end

  for (genvar s = 0; s < TAB_SIZE; s++) begin : g_speed_tab
    if (s < NUM_STEPS) begin : g_used
      assign spd_tab[s] = SPEED_TABLE[s*SPEED_W +: SPEED_W];
    end else begin : g_unused
      assign spd_tab[s] = '0;
    end
  end

  // One slew tick: move toward the goal by at most RAMP_STEP, landing exactly on it.
  function automatic logic [SPEED_W-1:0] slew(input logic [SPEED_W-1:0] cur,
                                              input logic [SPEED_W-1:0] tgt);
    logic [SPEED_W-1:0] lim;
    lim = SPEED_W'(RAMP_STEP);
    if (tgt > cur)      return ((tgt - cur) > lim) ? cur + lim : tgt;
    else if (cur > tgt) return ((cur - tgt) > lim) ? cur - lim : tgt;
    else                return cur;
  endfunction

  assign inc_p     = bus.increment & ~inc_q;
  assign dec_p     = bus.decrement & ~dec_q;
  assign tick      = (div_cnt == CNT_W'(RAMP_DIV - 1));
  assign sel_speed = spd_tab[idx];
  assign goal      = bus.run ? sel_speed : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      div_cnt     <= '0;
      motor_speed <= '0;
    end else begin
      inc_q   <= bus.increment;
      dec_q   <= bus.decrement;
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
      if (tick) motor_speed <= slew(motor_speed, goal);

      // Selection is frozen while spinning; an out-of-range idx after a mode change is
      // pulled back only by the next button edge.
      if (!bus.run) begin
        if (bus.load)
          idx <= dflt_tab[bus.wash_mode];
        else if (inc_p && !dec_p)
          idx <= (idx >= max_tab[bus.wash_mode]) ? '0 : idx + IDX_W'(1);
        else if (dec_p && !inc_p)
          idx <= (idx == '0) ? max_tab[bus.wash_mode] : idx - IDX_W'(1);
      end
    end
  end

  assign bus.selected_spin_speed = sel_speed;
  assign bus.motor_speed         = motor_speed;
  assign bus.at_speed            = bus.run & (motor_speed == sel_speed);
  assign bus.ramping             = (motor_speed != goal);

endmodule

// File: tb/tb_spin_speed_ramp_ctrl.sv
// Bench for spin_speed_ramp_ctrl: table-driven selection vectors, hand-written ramp and
// reset sequences, then randomized traffic against a cycle-level reference model.
module tb_spin_speed_ramp_ctrl;

  localparam int RAMP_DIV  = 4;
  localparam int RAMP_STEP = 200;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  spin_speed_ramp_if #(.MODE_W(3), .SPEED_W(11)) bus ();

  spin_speed_ramp_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int SPEEDS [6] = '{0, 400, 800, 1000, 1200, 1400};
  int DEFS   [8] = '{3, 5, 1, 4, 2, 0, 3, 5};
  int MAXS   [8] = '{5, 5, 2, 5, 3, 0, 4, 5};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_idx, m_motor, m_cyc;
  bit m_inc_prev, m_dec_prev;

  typedef struct {
    int mode;
    bit load;
    bit inc;
    bit dec;
    int exp_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_motor = 0; m_cyc = 0;
    m_inc_prev = 0; m_dec_prev = 0;
  endtask

  task automatic model_step();
    int goal;
    int mode;
    bit ip, dp;
    mode = int'(bus.wash_mode);
    goal = bus.run ? SPEEDS[m_idx] : 0;
    ip   = bus.increment && !m_inc_prev;
    dp   = bus.decrement && !m_dec_prev;
    if ((m_cyc % RAMP_DIV) == RAMP_DIV - 1) begin
      if (m_motor < goal)      m_motor += (goal - m_motor < RAMP_STEP) ? goal - m_motor : RAMP_STEP;
      else if (m_motor > goal) m_motor -= (m_motor - goal < RAMP_STEP) ? m_motor - goal : RAMP_STEP;
    end
    m_cyc++;
    if (!bus.run) begin
      if (bus.load)          m_idx = DEFS[mode];
      else if (ip && dp)     m_idx = m_idx;
      else if (ip)           m_idx = (m_idx >= MAXS[mode]) ? 0 : m_idx + 1;
      else if (dp)           m_idx = (m_idx == 0) ? MAXS[mode] : m_idx - 1;
    end
    m_inc_prev = bus.increment;
    m_dec_prev = bus.decrement;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    int goal;
    goal = bus.run ? SPEEDS[m_idx] : 0;
    chk({tag, "_sel"},   int'(bus.selected_spin_speed), SPEEDS[m_idx]);
    chk({tag, "_motor"}, int'(bus.motor_speed), m_motor);
    chk({tag, "_at"},    int'(bus.at_speed), int'(bus.run && (m_motor == SPEEDS[m_idx])));
    chk({tag, "_ramp"},  int'(bus.ramping), int'(m_motor != goal));
  endtask

  // Wait (bounded) for motor_speed to move, then check the new value; returns cycles waited.
  task automatic wait_motor(input string name, input int exp, input int limit, output int gap);
    int prev;
    prev = int'(bus.motor_speed);
    gap  = 0;
    while (int'(bus.motor_speed) == prev && gap < limit) begin
      cyc();
      gap++;
    end
    chk(name, int'(bus.motor_speed), exp);
  endtask

  task automatic wait_until_motor(input string name, input int target, input int limit);
    int n;
    n = 0;
    while (int'(bus.motor_speed) != target && n < limit) begin
      cyc();
      n++;
    end
    chk(name, int'(bus.motor_speed), target);
  endtask

  task automatic pulse_load(input int mode);
    bus.wash_mode = 3'(mode);
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_load [8] = '{1000, 1400, 400, 1200, 800, 0, 1000, 1400};
    int gap;

    // Selection vectors: one row per clock
    for (int m = 0; m < 8; m++) begin
      vecs.push_back('{m, 1'b1, 1'b0, 1'b0, exp_load[m]});
      vecs.push_back('{m, 1'b0, 1'b0, 1'b0, exp_load[m]});
    end
    vecs.push_back('{2, 1'b1, 1'b0, 1'b0, 400});
    vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 800});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 800});
    vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 400});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 400});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b1, 0});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b1, 800});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 800});
    vecs.push_back('{3, 1'b1, 1'b0, 1'b0, 1200});
    for (int k = 0; k < 10; k++) vecs.push_back('{3, 1'b0, 1'b1, 1'b0, 1400});
    vecs.push_back('{3, 1'b0, 1'b0, 1'b0, 1400});
    vecs.push_back('{3, 1'b0, 1'b1, 1'b1, 1400});
    vecs.push_back('{3, 1'b0, 1'b0, 1'b0, 1400});
    vecs.push_back('{3, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{3, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{3, 1'b0, 1'b0, 1'b1, 1400});
    vecs.push_back('{3, 1'b0, 1'b0, 1'b0, 1400});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 1400});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b1, 1200});
    vecs.push_back('{2, 1'b0, 1'b0, 1'b0, 1200});
    vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 0});

    bus.wash_mode = '0; bus.load = 0; bus.increment = 0; bus.decrement = 0; bus.run = 0;
    model_reset();
    #12;
    chk("reset_sel",   int'(bus.selected_spin_speed), 0);
    chk("reset_motor", int'(bus.motor_speed), 0);
    chk("reset_at",    int'(bus.at_speed), 0);
    chk("reset_ramp",  int'(bus.ramping), 0);
    cyc();
    reset = 1'b0;

    foreach (vecs[i]) begin
      bus.wash_mode = 3'(vecs[i].mode);
      bus.load      = vecs[i].load;
      bus.increment = vecs[i].inc;
      bus.decrement = vecs[i].dec;
      cyc();
      chk($sformatf("vec%0d_sel", i), int'(bus.selected_spin_speed), vecs[i].exp_sel);
      chk($sformatf("vec%0d_motor", i), int'(bus.motor_speed), 0);
    end
    bus.load = 0; bus.increment = 0; bus.decrement = 0;
    cyc();

    // Ramp up to 1400 in mode 1
    pulse_load(1);
    chk("m1_sel", int'(bus.selected_spin_speed), 1400);
    bus.run = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      wait_motor($sformatf("up_%0d", k * 200), k * 200, RAMP_DIV + 1, gap);
      if (k > 1) chk($sformatf("up_gap_%0d", k), gap, RAMP_DIV);
    end
    chk("up_at_speed", int'(bus.at_speed), 1);
    chk("up_ramping",  int'(bus.ramping), 0);
    bus.increment = 1'b1;
    cyc();
    bus.increment = 1'b0;
    cyc();
    chk("run_lock_sel", int'(bus.selected_spin_speed), 1400);

    // Spin down, select 1000, abort at 600
    bus.run = 1'b0;
    wait_until_motor("down_zero", 0, 40);
    pulse_load(0);
    chk("m0_sel", int'(bus.selected_spin_speed), 1000);
    bus.run = 1'b1;
    wait_until_motor("reach_600", 600, 30);
    bus.run = 1'b0;
    wait_motor("abort_400", 400, RAMP_DIV + 1, gap);
    wait_motor("abort_200", 200, RAMP_DIV + 1, gap);
    chk("abort_gap", gap, RAMP_DIV);
    wait_motor("abort_0", 0, RAMP_DIV + 1, gap);
    chk("abort_ramping", int'(bus.ramping), 0);

    // Reset mid-ramp with increment held across release
    pulse_load(1);
    bus.run = 1'b1;
    wait_until_motor("reach_800", 800, 30);
    #2;
    reset = 1'b1;
    bus.increment = 1'b1;
    bus.run = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_motor", int'(bus.motor_speed), 0);
    chk("rst_mid_sel",   int'(bus.selected_spin_speed), 0);
    chk("rst_mid_ramp",  int'(bus.ramping), 0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("rel_first_edge_sel", int'(bus.selected_spin_speed), 400);
    repeat (3) cyc();
    chk("rel_held_sel", int'(bus.selected_spin_speed), 400);
    bus.increment = 1'b0;
    cyc();
    check_model("sync");

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 29) == 0) bus.wash_mode = 3'($urandom_range(0, 7));
      bus.load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) bus.increment = ~bus.increment;
      if ($urandom_range(0, 3) == 0) bus.decrement = ~bus.decrement;
      cyc();
      check_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
